gf2p2_sc_sq_iter: RTL and testbench

GF2P2_SC_SQ_ITER -- requirements
Module: gf2p2_sc_sq_iter

---
 rtl/gf2p2_sc_sq_iter.sv | 102 ++++++++++
 tb/tb_gf2p2_sc_sq_iter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gf2p2_sc_sq_iter.sv
// Iterative GF(2^2) lane processor: applies square, scale or square-then-scale to every lane
// a programmable number of times, with valid/ready handshakes on both sides.
module gf2p2_sc_sq_iter #(
  parameter int unsigned LANES = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*LANES-1:0]   in_data,
  input  logic [1:0]           in_mode,
  input  logic [CNT_W-1:0]     in_count,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*LANES-1:0]   out_data,
  output logic                 busy
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q;
  logic [2*LANES-1:0] work_q;
  logic [2*LANES-1:0] work_step;
  logic [1:0]         mode_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;

  // One application of the latched operation to every lane; lanes are independent.
  always_comb begin
    work_step = work_q;
    for (int k = 0; k < int'(LANES); k++) begin
      unique case (mode_q)
        2'b00: work_step[2*k +: 2] = work_q[2*k +: 2];
        2'b01: work_step[2*k +: 2] = {work_q[2*k], work_q[2*k+1]};
        2'b10: work_step[2*k +: 2] = {work_q[2*k], work_q[2*k+1] ^ work_q[2*k]};
        2'b11: work_step[2*k +: 2] = {work_q[2*k+1], work_q[2*k] ^ work_q[2*k+1]};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      work_q      <= '0;
      mode_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            work_q     <= in_data;
            mode_q     <= in_mode;
            cnt_q      <= in_count;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (in_count == '0) begin
              state_q     <= StDone;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          work_q <= work_step;
          cnt_q  <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
          end
        end
        StDone: begin
          // Result and out_valid hold until downstream takes them.
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = work_q;

endmodule

// File: tb/tb_gf2p2_sc_sq_iter.sv
// Scoreboard bench for gf2p2_sc_sq_iter: driver pushes expected results on accept, a monitor
// pops and compares whenever a result is handed over.
module tb_gf2p2_sc_sq_iter;

  localparam int LANES = 4;
  localparam int CNT_W = 3;
  localparam int DW    = 2 * LANES;

  // Per-element maps indexed [mode][value], value = {A[1],A[0]} as an integer.
  localparam int LUT [4][4] = '{'{0, 1, 2, 3}, '{0, 2, 1, 3}, '{0, 3, 1, 2}, '{0, 1, 3, 2}};

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DW-1:0]    in_data = '0;
  logic [1:0]       in_mode = '0;
  logic [CNT_W-1:0] in_count = '0;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic             busy;

  gf2p2_sc_sq_iter #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_mode  (in_mode),
    .in_count (in_count),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            n;
    int            acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rdy_mode = 1;  // 0: hold low, 1: hold high, 2: random
  logic offering = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] model(input logic [DW-1:0] a, input logic [1:0] m,
                                          input int n);
    logic [DW-1:0] r;
    for (int l = 0; l < LANES; l++) begin
      int v = int'(a[2*l +: 2]);
      for (int i = 0; i < n; i++) v = LUT[m][v];
      r[2*l +: 2] = v[1:0];
    end
    return r;
  endfunction

  task automatic send_exp(input logic [DW-1:0] d, input logic [1:0] m, input int n,
                          input logic [DW-1:0] exp);
    bit acc = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    in_count = CNT_W'(n);
    offering = 1'b1;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back('{data: exp, n: n, acc: cyc});
        acc = 1;
      end
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    offering = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [1:0] m, input int n);
    send_exp(d, m, n, model(d, m, n));
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = (q.size() == 0) && in_ready;
    end
    if (!done) check("drain_timeout", 32'd0, 32'd1);
  endtask

  // Monitor
  logic          prev_ov = 1'b0;
  logic          hold_prev = 1'b0;
  logic [DW-1:0] held = '0;
  int            rise_cyc = 0;
  exp_t          e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov   = 1'b0;
      hold_prev = 1'b0;
    end else begin
      if (in_valid && !offering) check("spurious_accept", 32'(in_ready), 32'd0);
      if (hold_prev) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(held));
      end
      if (out_valid && !prev_ov) rise_cyc = cyc;
      prev_ov = out_valid;
      if (out_valid) begin
        check("busy_in_done", 32'(busy), 32'd1);
        check("ready_in_done", 32'(in_ready), 32'd0);
        if (q.size() == 0) begin
          check("stale_output", 32'(out_valid), 32'd0);
        end else if (out_ready) begin
          e = q.pop_front();
          check("out_data", 32'(out_data), 32'(e.data));
          check("latency", 32'(rise_cyc - e.acc), 32'(e.n + 1));
        end
      end
      hold_prev = out_valid && !out_ready;
      held      = out_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed vectors with known answers
    rdy_mode = 1;
    send_exp(8'hE4, 2'b01, 1, 8'hD8);
    send_exp(8'hE4, 2'b11, 1, 8'hB4);
    send_exp(8'hE4, 2'b11, 2, 8'hE4);
    send_exp(8'hE4, 2'b10, 3, 8'hE4);
    send_exp(8'hE4, 2'b10, 1, 8'h9C);
    for (int m = 0; m < 4; m++) send_exp(8'h5A, 2'(m), 0, 8'h5A);
    send_exp(8'hE4, 2'b00, 5, 8'hE4);
    send(8'hA5, 2'b01, 7);
    send(8'h6C, 2'b10, 7);
    wait_drain();

    // Backpressure: result held while out_ready low, in_valid ignored
    rdy_mode = 0;
    send_exp(8'hE4, 2'b01, 1, 8'hD8);
    in_valid = 1'b1;
    in_data  = 8'h33;
    in_mode  = 2'b11;
    in_count = 3'd2;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    check("bp_reached_done", 32'(seen), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_data", 32'(out_data), 32'hD8);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rdy_mode = 1;
    wait_drain();

    // Reset during RUN aborts with no output
    send(8'hE4, 2'b10, 7);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_out_data", 32'(out_data), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (15) @(negedge clk);

    // Randomized traffic with random backpressure
    rdy_mode = 2;
    for (int t = 0; t < 60; t++) begin
      send(DW'($urandom), 2'($urandom_range(0, 3)), $urandom_range(0, 7));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    rdy_mode = 1;
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
